adder_result_tx: RTL and testbench
==================================

# adder_result_tx

Result serializer on the output side of the 64-bit adder. Captures one adder result (sum plus carry-out) through a valid/ready handshake and streams it as a fixed-length byte frame to the UART transmitter. It is the return path of the UART adder datapath: operands arrive over UART, the adder computes the result, and this block hands it back out byte by byte.

## Interface

Parameters:
- `W`, default 64: sum width in bits. Must be a multiple of 8 and at least 8.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `res_valid`  in  1  adder result valid.
- `res_sum`  in  W  adder sum.
- `res_cout`  in  1  adder carry-out.
- `res_ready`  out  1  block can accept a result.
- `tx_data`  out  8  byte to the UART transmitter.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  UART transmitter accepts the byte.
- `busy`  out  1  frame in progress (inverse of `res_ready`).

## Operation

- States:
  - IDLE: `res_ready`=1, `tx_valid`=0.
  - SEND: stream data bytes.
  - CSUM: checksum byte; exists only with the macro.
- Capture:
  - In IDLE, `res_valid`&&`res_ready` at an edge registers `res_sum` and `res_cout`, clears the byte index and checksum accumulator, and moves to SEND.
  - After capture, the input bus is ignored until the block returns to IDLE.
- Frame order:
  - Byte 0 = {7'b0, cout}.
  - Then the sum, MSB byte first: `sum[W-1:W-8]` … `sum[7:0]`.
  - Data length is W/8+1 bytes; 9 bytes for W=64.
- Output handshake:
  - In SEND and CSUM, `tx_valid`=1 and `tx_data` is the current byte.
  - `tx_data` stays stable while `tx_valid`&&!`tx_ready`.
  - The byte index advances only on `tx_valid`&&`tx_ready`.
- Byte index:
  - Counter width is $clog2(W/8+2).
  - The index never wraps within a frame.
  - On the last data byte's handshake: go to CSUM if the macro is defined, otherwise go to IDLE.
- Checksum accumulator: XOR of every data byte accepted in the current frame.
- Reset:
  - `rst_n` low at any time, including mid-frame, forces IDLE immediately.
  - The partial frame is discarded and never resumed.

## Timing

- Reset values:
  - `res_ready`=1, `busy`=0, `tx_valid`=0, `tx_data`=8'h00.
  - Internal registers are zero.
- Latency: capture at edge N puts `tx_valid`=1 with byte 0 on `tx_data` after edge N (visible in cycle N+1).
- Throughput: one byte per cycle while `tx_ready` is held high. A 9-byte frame occupies exactly 9 cycles in SEND.
- Frame end: the final byte's handshake at edge M gives `tx_valid`=0 and `res_ready`=1 after edge M.
- Back-to-back frames: a new result can be captured at edge M+1 at the earliest. There is no same-cycle turnaround.
- `res_valid` asserted while busy: no effect. The producer holds it until `res_ready` returns.
- `tx_ready` asserted while `tx_valid`=0: ignored.
- `tx_data` is registered and driven only from state/registers. `tx_ready` has no combinational path to any output.

## Configuration

- Macro: `ADDER_RESULT_TX_CHECKSUM_EN`.
- Defined:
  - After the last data byte, CSUM sends one extra byte equal to the XOR of all data bytes, under the same handshake.
  - The frame is W/8+2 bytes (10 for W=64).
  - CSUM goes to IDLE on its handshake.
- Undefined:
  - No CSUM state and no accumulator.
  - The frame is W/8+1 bytes.

## Test plan

- Reset state: `rst_n`=0 → `res_ready`=1, `tx_valid`=0, `tx_data`=00. Release `rst_n`, hold `res_valid`=0 for 10 cycles → outputs unchanged.
- Basic frame, `tx_ready`=1 throughout:
  - Stimulus: sum=64'h0123456789ABCDEF, cout=1.
  - Required bytes, one per cycle starting the cycle after capture: 01 01 23 45 67 89 AB CD EF.
  - Checksum byte 01 with the macro.
  - `res_ready`=1 the cycle after the last handshake.
- Backpressure:
  - Stimulus: same input; drop `tx_ready` for 5 cycles while byte 45 is presented.
  - Required: `tx_data`=45 and `tx_valid`=1 held stable for all 5 cycles.
  - Sequence resumes with 67 and the frame content is unaltered.
- Extremes:
  - sum=all 1s, cout=1 → 01 followed by eight FF (checksum 01).
  - sum=0, cout=0 → nine 00 (checksum 00).
- Busy and back-to-back:
  - `res_valid` held high with a new value during a frame → not captured until IDLE.
  - Second frame begins exactly 1 cycle after the first frame's last handshake.
- Mid-frame reset:
  - Stimulus: assert `rst_n`=0 during byte 4.
  - Required: outputs go to reset values asynchronously.
  - A new capture after release sends a full frame starting at byte 0.

Source files
------------

// File: rtl/adder_result_tx_if.sv
// ---------------------------------------------------------------------------
// adder_result_tx_if
//
// Purpose: bundles the two handshakes around the adder result serializer.
//   - result side: the adder offers a sum/carry pair with res_valid and the
//     serializer accepts it with res_ready.
//   - byte side: the serializer offers tx_data with tx_valid and the UART
//     transmitter takes it with tx_ready.
//
// Signals:
//   res_valid  adder result valid             (producer -> serializer)
//   res_sum    W-bit adder sum                (producer -> serializer)
//   res_cout   adder carry-out                (producer -> serializer)
//   res_ready  serializer can take a result   (serializer -> producer)
//   tx_data    byte for the UART transmitter  (serializer -> UART)
//   tx_valid   tx_data valid                  (serializer -> UART)
//   tx_ready   UART accepts the byte          (UART -> serializer)
//   busy       frame in progress              (serializer -> system)
//
// Modports:
//   slave   the serializer itself
//   master  the environment around it (adder producer + UART transmitter)
// ---------------------------------------------------------------------------
interface adder_result_tx_if #(
    parameter int W = 64
);
    logic         res_valid;
    logic [W-1:0] res_sum;
    logic         res_cout;
    logic         res_ready;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         busy;

    modport slave (
        input  res_valid,
        input  res_sum,
        input  res_cout,
        output res_ready,
        output tx_data,
        output tx_valid,
        input  tx_ready,
        output busy
    );

    modport master (
        output res_valid,
        output res_sum,
        output res_cout,
        input  res_ready,
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        input  busy
    );
endinterface

// File: rtl/adder_result_tx.sv
// ---------------------------------------------------------------------------
// adder_result_tx
//
// Purpose: return path of the UART adder datapath. Captures one adder result
// (sum plus carry-out) and streams it to the UART transmitter as a byte frame:
//   byte 0      = {7'b0, cout}
//   bytes 1..N  = sum, most significant byte first (N = W/8)
//   byte N+1    = XOR of bytes 0..N (only with ADDER_RESULT_TX_CHECKSUM_EN)
//
// Parameters:
//   W  sum width in bits, a multiple of 8 and at least 8.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset; aborts any frame in progress
//   bus    adder_result_tx_if.slave: res_valid/res_sum/res_cout/res_ready
//          result handshake, tx_data/tx_valid/tx_ready byte handshake, busy
//
// Configuration macro:
//   ADDER_RESULT_TX_CHECKSUM_EN  appends the XOR checksum byte (CSUM state).
//   Left undefined, the frame is W/8+1 bytes and no accumulator exists.
// ---------------------------------------------------------------------------
module adder_result_tx #(
    parameter int W = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    adder_result_tx_if.slave   bus
);

    localparam int NBYTES = W / 8;
    localparam int IW     = $clog2(NBYTES + 2);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1
`ifdef ADDER_RESULT_TX_CHECKSUM_EN
        ,
        CSUM = 2'd2
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    sum_q, sum_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [7:0]      tx_data_q, tx_data_d;
`ifdef ADDER_RESULT_TX_CHECKSUM_EN
    logic [7:0]      csum_q, csum_d;
`endif

    // State and datapath registers; reset drops any partial frame at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sum_q     <= '0;
            idx_q     <= '0;
            tx_data_q <= '0;
`ifdef ADDER_RESULT_TX_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sum_q     <= sum_d;
            idx_q     <= idx_d;
            tx_data_q <= tx_data_d;
`ifdef ADDER_RESULT_TX_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    // Next-state logic. The sum is held in a shift register: the byte that
    // goes out next is always its top byte, so tx_data can be loaded from a
    // fixed slice instead of a wide index mux. tx_data_q always holds the
    // byte currently on offer, which keeps it stable under backpressure.
    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        idx_d     = idx_q;
        tx_data_d = tx_data_q;
`ifdef ADDER_RESULT_TX_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.res_valid) begin
                    sum_d     = bus.res_sum;
                    tx_data_d = {7'b0, bus.res_cout};
                    idx_d     = '0;
`ifdef ADDER_RESULT_TX_CHECKSUM_EN
                    csum_d    = '0;
`endif
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (bus.tx_ready) begin
                    idx_d = idx_q + IW'(1);
`ifdef ADDER_RESULT_TX_CHECKSUM_EN
                    csum_d = csum_q ^ tx_data_q;
`endif
                    if (idx_q == LAST_IDX) begin
`ifdef ADDER_RESULT_TX_CHECKSUM_EN
                        // Checksum includes the byte just accepted.
                        tx_data_d = csum_q ^ tx_data_q;
                        state_d   = CSUM;
`else
                        tx_data_d = '0;
                        state_d   = IDLE;
`endif
                    end else begin
                        tx_data_d = sum_q[W-1 -: 8];
                        sum_d     = sum_q << 8;
                    end
                end
            end
`ifdef ADDER_RESULT_TX_CHECKSUM_EN
            CSUM: begin
                if (bus.tx_ready) begin
                    idx_d     = idx_q + IW'(1);
                    tx_data_d = '0;
                    state_d   = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All outputs come straight from registers; tx_ready never reaches them.
    assign bus.res_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.tx_valid  = (state_q != IDLE);
    assign bus.tx_data   = tx_data_q;

endmodule

// File: tb/tb_adder_result_tx.sv
// ---------------------------------------------------------------------------
// tb_adder_result_tx
//
// Bench for adder_result_tx. Expected frames are built from the byte layout
// of a result (carry byte, then the sum MSB byte first, optional XOR byte)
// and compared against what appears on the tx handshake.
// ---------------------------------------------------------------------------
module tb_adder_result_tx;

    localparam int W  = 64;
    localparam int NB = W / 8;

    logic clk = 1'b0;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    // Bytes the current frame should carry, in order.
    logic [7:0] expQ[$];

    adder_result_tx_if #(.W(W)) bus ();

    adder_result_tx #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10-time-unit clock; rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Single comparison point: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Builds the expected frame from the result by plain arithmetic:
    // carry as its own byte, then each sum byte from the top down.
    task automatic buildFrame(input logic [W-1:0] s, input logic c);
        logic [7:0] x;
        expQ.delete();
        expQ.push_back({7'b0, c});
        for (int k = NB - 1; k >= 0; k--)
            expQ.push_back(8'((s / (64'd1 << (8 * k))) % 256));
`ifdef ADDER_RESULT_TX_CHECKSUM_EN
        x = 8'h00;
        foreach (expQ[i]) x = x ^ expQ[i];
        expQ.push_back(x);
`endif
    endtask

    // Offers one result while the block is idle (called on a falling edge),
    // lets the next rising edge capture it, optionally keeps res_valid high.
    task automatic applyStimulus(input logic [W-1:0] s, input logic c, input bit hold);
        checkOutput("res_ready_before_capture", 64'(bus.res_ready), 64'd1);
        bus.res_valid = 1'b1;
        bus.res_sum   = s;
        bus.res_cout  = c;
        @(negedge clk);
        if (!hold) bus.res_valid = 1'b0;
    endtask

    // Checks that byte i of the expected frame is on offer.
    task automatic checkByte(input int i);
        checkOutput($sformatf("tx_valid[%0d]", i), 64'(bus.tx_valid), 64'd1);
        checkOutput($sformatf("tx_data[%0d]", i), 64'(bus.tx_data), 64'(expQ[i]));
        checkOutput($sformatf("busy[%0d]", i), 64'(bus.busy), 64'd1);
        checkOutput($sformatf("res_ready[%0d]", i), 64'(bus.res_ready), 64'd0);
    endtask

    // Accepts up to stopAfter bytes, stalling stallLen cycles on byte
    // stallAt or a random 0..2 cycles per byte; after a complete frame the
    // block must be idle again right after the last handshake.
    task automatic drainFrame(input int stopAfter, input int stallAt,
                              input int stallLen, input bit randomStall);
        for (int i = 0; i < expQ.size() && i < stopAfter; i++) begin
            int w;
            w = (i == stallAt) ? stallLen : (randomStall ? int'($urandom_range(0, 2)) : 0);
            for (int k = 0; k < w; k++) begin
                bus.tx_ready = 1'b0;
                checkByte(i);
                @(negedge clk);
            end
            bus.tx_ready = 1'b1;
            checkByte(i);
            @(negedge clk);
        end
        if (stopAfter >= expQ.size()) begin
            checkOutput("frame_end_tx_valid", 64'(bus.tx_valid), 64'd0);
            checkOutput("frame_end_res_ready", 64'(bus.res_ready), 64'd1);
            checkOutput("frame_end_busy", 64'(bus.busy), 64'd0);
        end
    endtask

    // Directed sequence: reset, basic, backpressure, extremes, busy and
    // back-to-back, randomized frames, mid-frame reset.
    initial begin
        logic [W-1:0] s;
        logic         c;

        rst_n         = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_sum   = '0;
        bus.res_cout  = 1'b0;
        bus.tx_ready  = 1'b0;

        #3;
        checkOutput("reset_res_ready", 64'(bus.res_ready), 64'd1);
        checkOutput("reset_busy", 64'(bus.busy), 64'd0);
        checkOutput("reset_tx_valid", 64'(bus.tx_valid), 64'd0);
        checkOutput("reset_tx_data", 64'(bus.tx_data), 64'h00);

        // Idle after release, with a stray tx_ready that must be ignored.
        @(negedge clk);
        rst_n        = 1'b1;
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("idle_res_ready", 64'(bus.res_ready), 64'd1);
            checkOutput("idle_tx_valid", 64'(bus.tx_valid), 64'd0);
            checkOutput("idle_tx_data", 64'(bus.tx_data), 64'h00);
        end
        bus.tx_ready = 1'b0;

        $display("[TB] basic frame");
        buildFrame(64'h0123456789ABCDEF, 1'b1);
        applyStimulus(64'h0123456789ABCDEF, 1'b1, 1'b0);
        drainFrame(100, -1, 0, 1'b0);

        $display("[TB] backpressure on byte 3");
        buildFrame(64'h0123456789ABCDEF, 1'b1);
        applyStimulus(64'h0123456789ABCDEF, 1'b1, 1'b0);
        drainFrame(100, 3, 5, 1'b0);

        $display("[TB] extremes");
        buildFrame({W{1'b1}}, 1'b1);
        applyStimulus({W{1'b1}}, 1'b1, 1'b0);
        drainFrame(100, -1, 0, 1'b0);
        buildFrame('0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
        drainFrame(100, -1, 0, 1'b0);

        // res_valid stays high with a new result during the first frame; the
        // new result is taken on the edge right after the last handshake.
        $display("[TB] busy and back-to-back");
        buildFrame(64'hDEADBEEFCAFEF00D, 1'b0);
        applyStimulus(64'hDEADBEEFCAFEF00D, 1'b0, 1'b1);
        bus.res_sum  = 64'h1122334455667788;
        bus.res_cout = 1'b1;
        drainFrame(100, 1, 2, 1'b0);
        @(negedge clk);
        bus.res_valid = 1'b0;
        buildFrame(64'h1122334455667788, 1'b1);
        drainFrame(100, -1, 0, 1'b0);

        $display("[TB] randomized frames");
        for (int f = 0; f < 8; f++) begin
            s = {$urandom(), $urandom()};
            c = 1'($urandom_range(0, 1));
            buildFrame(s, c);
            applyStimulus(s, c, 1'b0);
            drainFrame(100, -1, 0, 1'b1);
        end

        // Reset lands while byte 4 is on offer, between clock edges.
        $display("[TB] mid-frame reset");
        s = 64'hA5A5_0F0F_F0F0_5A5A;
        buildFrame(s, 1'b1);
        applyStimulus(s, 1'b1, 1'b0);
        drainFrame(4, -1, 0, 1'b0);
        checkByte(4);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_res_ready", 64'(bus.res_ready), 64'd1);
        checkOutput("midreset_busy", 64'(bus.busy), 64'd0);
        checkOutput("midreset_tx_valid", 64'(bus.tx_valid), 64'd0);
        checkOutput("midreset_tx_data", 64'(bus.tx_data), 64'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("postreset_tx_valid", 64'(bus.tx_valid), 64'd0);
        s = 64'h0F1E2D3C4B5A6978;
        buildFrame(s, 1'b0);
        applyStimulus(s, 1'b0, 1'b0);
        drainFrame(100, -1, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
